// File: rtl/dma_host_bus_agent.sv
// Host-side bus agent for an 8237A: issues slave-mode register cycles and grants the bus on HRQ.
// Optional build macro DMA_HOST_HOLD_TIMEOUT_EN adds a sticky hold_timeout report output.
module dma_host_bus_agent #(
  parameter int HLDA_DELAY    = 2,
  parameter int STROBE_CYCLES = 2,
  parameter int HOLD_TIMEOUT  = 1024
) (
  input  logic       CLOCK,
  input  logic       RESET_N,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic       cmd_write,
  input  logic [3:0] cmd_addr,
  input  logic [7:0] cmd_wdata,
  output logic       rsp_valid,
  output logic [7:0] rsp_rdata,
  output logic       CS_N,
  inout  wire        IOR_N,
  inout  wire        IOW_N,
  inout  wire  [3:0] ADDRESS,
  inout  wire  [7:0] DATABUS,
  input  logic       HRQ,
  output logic       HLDA,
`ifdef DMA_HOST_HOLD_TIMEOUT_EN
  output logic       hold_active,
  output logic       hold_timeout
`else
  output logic       hold_active
`endif
);

  typedef enum logic [2:0] {
    IDLE, SETUP, STROBE, RECOVER, HOLD_WAIT, HOLD, RELEASE
  } state_t;

  localparam logic [3:0] HLDA_LAST   = 4'(HLDA_DELAY - 1);
  localparam logic [3:0] STROBE_LAST = 4'(STROBE_CYCLES - 1);

  state_t     state, state_nxt;
  logic [3:0] cnt, cnt_nxt;
  logic       wr_q;
  logic [3:0] addr_q;
  logic [7:0] wdata_q;
  logic [7:0] rdata_q;
  logic       accept;
  logic       strobe_last;
  logic       ctl_drive, addr_drive, data_drive;
  logic       ior_n_val, iow_n_val;

  assign cmd_ready   = RESET_N && (state == IDLE) && !HRQ;
  assign accept      = cmd_valid && cmd_ready;
  assign strobe_last = (state == STROBE) && (cnt == STROBE_LAST);

  always_comb begin
    state_nxt = state;
    cnt_nxt   = '0;
    unique case (state)
      IDLE: begin
        if (HRQ)         state_nxt = HOLD_WAIT;
        else if (accept) state_nxt = SETUP;
      end
      SETUP: state_nxt = STROBE;
      STROBE: begin
        if (cnt == STROBE_LAST) state_nxt = RECOVER;
        else                    cnt_nxt   = cnt + 4'd1;
      end
      RECOVER: state_nxt = IDLE;
      HOLD_WAIT: begin
        if (!HRQ)                   state_nxt = IDLE;
        else if (cnt == HLDA_LAST)  state_nxt = HOLD;
        else                        cnt_nxt   = cnt + 4'd1;
      end
      HOLD: begin
        if (!HRQ) state_nxt = RELEASE;
      end
      RELEASE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLOCK) begin
    if (!RESET_N) begin
      state   <= IDLE;
      cnt     <= '0;
      rdata_q <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (strobe_last && !wr_q) rdata_q <= DATABUS;
    end
  end

  // Command fields are plain data: captured on the accepting edge, never reset.
  always_ff @(posedge CLOCK) begin
    if (accept) begin
      wr_q    <= cmd_write;
      addr_q  <= cmd_addr;
      wdata_q <= cmd_wdata;
    end
  end

  // Strobes are owned by this block except while the controller holds the bus.
  assign ctl_drive  = (state != HOLD) && (state != RELEASE);
  assign addr_drive = (state == SETUP) || (state == STROBE);
  assign data_drive = addr_drive && wr_q;
  assign ior_n_val  = !((state == STROBE) && !wr_q);
  assign iow_n_val  = !((state == STROBE) && wr_q);

  assign IOR_N   = ctl_drive  ? ior_n_val : 1'bz;
  assign IOW_N   = ctl_drive  ? iow_n_val : 1'bz;
  assign ADDRESS = addr_drive ? addr_q    : 4'bzzzz;
  assign DATABUS = data_drive ? wdata_q   : 8'hzz;

  assign CS_N        = !addr_drive;
  assign HLDA        = (state == HOLD);
  assign hold_active = HLDA;
  assign rsp_valid   = (state == RECOVER) && !wr_q;
  assign rsp_rdata   = rdata_q;

`ifdef DMA_HOST_HOLD_TIMEOUT_EN
  localparam logic [15:0] TO_LAST = 16'(HOLD_TIMEOUT - 1);

  logic [15:0] hold_cnt;
  logic        to_flag;
  logic        to_hit;

  // Counter restarts each hold period; the flag is report-only and sticky until reset.
  assign to_hit       = (state == HOLD) && (hold_cnt >= TO_LAST);
  assign hold_timeout = to_flag || to_hit;

  always_ff @(posedge CLOCK) begin
    if (!RESET_N) begin
      hold_cnt <= '0;
      to_flag  <= 1'b0;
    end else begin
      if (state != HOLD)              hold_cnt <= '0;
      else if (hold_cnt != 16'hFFFF)  hold_cnt <= hold_cnt + 16'd1;
      if (to_hit) to_flag <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_dma_host_bus_agent.sv
// Directed bench for dma_host_bus_agent: slave write/read cycles, hold grant/release, collisions.
module tb_dma_host_bus_agent;

  logic       CLOCK = 1'b0;
  logic       RESET_N;
  logic       cmd_valid, cmd_write;
  logic [3:0] cmd_addr;
  logic [7:0] cmd_wdata;
  logic       cmd_ready, rsp_valid, CS_N, HRQ, HLDA, hold_active;
  logic [7:0] rsp_rdata;
  wire        IOR_N, IOW_N;
  wire  [3:0] ADDRESS;
  wire  [7:0] DATABUS;
`ifdef DMA_HOST_HOLD_TIMEOUT_EN
  logic       hold_timeout;
`endif

  // Bench plays the controller: drives the shared lines low in hold, and read data during IOR_N.
  logic       tb_ctl_en = 1'b0;
  logic       tb_bus_en = 1'b0;
  logic       tb_db_en  = 1'b0;
  logic [7:0] tb_rd_data = 8'h00;
  logic       mon_en = 1'b0;

  assign IOR_N   = tb_ctl_en ? 1'b0 : 1'bz;
  assign IOW_N   = tb_ctl_en ? 1'b0 : 1'bz;
  assign ADDRESS = tb_bus_en ? 4'h0 : 4'bzzzz;
  assign DATABUS = tb_bus_en ? 8'h00 : (tb_db_en ? tb_rd_data : 8'hzz);

  int checks   = 0;
  int failures = 0;

  dma_host_bus_agent #(.HLDA_DELAY(2), .STROBE_CYCLES(2), .HOLD_TIMEOUT(16)) dut (
    .CLOCK(CLOCK), .RESET_N(RESET_N),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .CS_N(CS_N), .IOR_N(IOR_N), .IOW_N(IOW_N), .ADDRESS(ADDRESS), .DATABUS(DATABUS),
    .HRQ(HRQ), .HLDA(HLDA),
`ifdef DMA_HOST_HOLD_TIMEOUT_EN
    .hold_timeout(hold_timeout),
`endif
    .hold_active(hold_active)
  );

  always #5 CLOCK = ~CLOCK;

  task automatic tick;
    @(posedge CLOCK);
    #1;
  endtask

  always @(negedge CLOCK) begin
    if (mon_en && !tb_ctl_en) begin
      checks++;
      if (IOR_N === 1'b0 && IOW_N === 1'b0) begin
        failures++; $display("FAIL strobe_overlap IOR_N=%b IOW_N=%b required not both 0", IOR_N, IOW_N);
      end
      checks++;
      if (HLDA === 1'b1 && CS_N === 1'b0) begin
        failures++; $display("FAIL hlda_with_cs HLDA=%b CS_N=%b required CS_N=1", HLDA, CS_N);
      end
    end
  end

  task automatic test_reset;
    RESET_N = 1'b0; HRQ = 1'b1; cmd_valid = 1'b1; cmd_write = 1'b1;
    cmd_addr = 4'h3; cmd_wdata = 8'hFF;
    tick; tick;
    checks++; if (CS_N !== 1'b1) begin failures++; $display("FAIL rst_cs_n got=%b exp=1", CS_N); end
    checks++; if (IOR_N !== 1'b1) begin failures++; $display("FAIL rst_ior_n got=%b exp=1", IOR_N); end
    checks++; if (IOW_N !== 1'b1) begin failures++; $display("FAIL rst_iow_n got=%b exp=1", IOW_N); end
    checks++; if (HLDA !== 1'b0) begin failures++; $display("FAIL rst_hlda got=%b exp=0", HLDA); end
    checks++; if (hold_active !== 1'b0) begin failures++; $display("FAIL rst_hold_active got=%b exp=0", hold_active); end
    checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL rst_rsp_valid got=%b exp=0", rsp_valid); end
    checks++; if (rsp_rdata !== 8'h00) begin failures++; $display("FAIL rst_rsp_rdata got=%h exp=00", rsp_rdata); end
    HRQ = 1'b0; #1;
    checks++; if (cmd_ready !== 1'b0) begin failures++; $display("FAIL rst_cmd_ready got=%b exp=0", cmd_ready); end
    tick;
    checks++; if (CS_N !== 1'b1) begin failures++; $display("FAIL rst_no_cycle CS_N got=%b exp=1", CS_N); end
    cmd_valid = 1'b0; RESET_N = 1'b1; #1;
    checks++; if (cmd_ready !== 1'b1) begin failures++; $display("FAIL idle_cmd_ready got=%b exp=1", cmd_ready); end
    mon_en = 1'b1;
  endtask

  task automatic test_write;
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 4'hB; cmd_wdata = 8'h48;
    tick;
    cmd_valid = 1'b0; cmd_wdata = 8'h00; cmd_addr = 4'h0; #1;
    checks++; if (CS_N !== 1'b0) begin failures++; $display("FAIL wr_setup_cs got=%b exp=0", CS_N); end
    checks++; if (IOW_N !== 1'b1 || IOR_N !== 1'b1) begin failures++; $display("FAIL wr_setup_strobes got=%b%b exp=11", IOR_N, IOW_N); end
    checks++; if (ADDRESS !== 4'hB || DATABUS !== 8'h48) begin failures++; $display("FAIL wr_setup_bus got=%h/%h exp=b/48", ADDRESS, DATABUS); end
    for (int i = 0; i < 2; i++) begin
      tick;
      checks++; if (IOW_N !== 1'b0 || IOR_N !== 1'b1) begin failures++; $display("FAIL wr_strobe%0d IOR_N/IOW_N got=%b%b exp=10", i, IOR_N, IOW_N); end
      checks++; if (CS_N !== 1'b0) begin failures++; $display("FAIL wr_strobe%0d_cs got=%b exp=0", i, CS_N); end
      checks++; if (ADDRESS !== 4'hB || DATABUS !== 8'h48) begin failures++; $display("FAIL wr_strobe%0d_bus got=%h/%h exp=b/48", i, ADDRESS, DATABUS); end
      checks++; if (cmd_ready !== 1'b0) begin failures++; $display("FAIL wr_strobe%0d_ready got=%b exp=0", i, cmd_ready); end
    end
    tick;
    checks++; if (CS_N !== 1'b1 || IOW_N !== 1'b1) begin failures++; $display("FAIL wr_recover CS_N/IOW_N got=%b%b exp=11", CS_N, IOW_N); end
    checks++; if (rsp_valid !== 1'b0 || cmd_ready !== 1'b0) begin failures++; $display("FAIL wr_recover rsp_valid/cmd_ready got=%b%b exp=00", rsp_valid, cmd_ready); end
    tick;
    checks++; if (cmd_ready !== 1'b1) begin failures++; $display("FAIL wr_ready_return got=%b exp=1", cmd_ready); end
  endtask

  task automatic test_read;
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 4'h8; cmd_wdata = 8'hA5;
    tick;
    cmd_valid = 1'b0;
    checks++; if (CS_N !== 1'b0 || IOR_N !== 1'b1 || ADDRESS !== 4'h8) begin failures++; $display("FAIL rd_setup CS_N/IOR_N/ADDR got=%b%b/%h exp=01/8", CS_N, IOR_N, ADDRESS); end
    tick;
    checks++; if (IOR_N !== 1'b0 || IOW_N !== 1'b1) begin failures++; $display("FAIL rd_strobe IOR_N/IOW_N got=%b%b exp=01", IOR_N, IOW_N); end
    tb_rd_data = 8'h5A; tb_db_en = 1'b1;
    tick;
    checks++; if (IOR_N !== 1'b0 || DATABUS !== 8'h5A) begin failures++; $display("FAIL rd_strobe_data IOR_N/DATABUS got=%b/%h exp=0/5a", IOR_N, DATABUS); end
    checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL rd_early_rsp got=%b exp=0", rsp_valid); end
    tick;
    tb_db_en = 1'b0;
    checks++; if (rsp_valid !== 1'b1 || rsp_rdata !== 8'h5A) begin failures++; $display("FAIL rd_rsp valid/data got=%b/%h exp=1/5a", rsp_valid, rsp_rdata); end
    checks++; if (CS_N !== 1'b1 || IOR_N !== 1'b1) begin failures++; $display("FAIL rd_recover CS_N/IOR_N got=%b%b exp=11", CS_N, IOR_N); end
    tick;
    checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL rd_rsp_pulse got=%b exp=0", rsp_valid); end
  endtask

  task automatic test_hold_grant;
    HRQ = 1'b1; #1;
    checks++; if (cmd_ready !== 1'b0) begin failures++; $display("FAIL hg_ready_hrq got=%b exp=0", cmd_ready); end
    tick;
    checks++; if (HLDA !== 1'b0 || IOR_N !== 1'b1) begin failures++; $display("FAIL hg_edge1 HLDA/IOR_N got=%b%b exp=01", HLDA, IOR_N); end
    tick;
    checks++; if (HLDA !== 1'b0) begin failures++; $display("FAIL hg_edge2 HLDA got=%b exp=0", HLDA); end
    tick;
    checks++; if (HLDA !== 1'b1 || hold_active !== 1'b1 || CS_N !== 1'b1) begin failures++; $display("FAIL hg_edge3 HLDA/hold_active/CS_N got=%b%b%b exp=111", HLDA, hold_active, CS_N); end
    tb_ctl_en = 1'b1; tb_bus_en = 1'b1; #1;
    checks++; if (IOR_N !== 1'b0 || IOW_N !== 1'b0) begin failures++; $display("FAIL hg_strobes_released got=%b%b exp=00", IOR_N, IOW_N); end
    checks++; if (ADDRESS !== 4'h0 || DATABUS !== 8'h00) begin failures++; $display("FAIL hg_bus_released got=%h/%h exp=0/00", ADDRESS, DATABUS); end
    HRQ = 1'b0;
    tick;
    checks++; if (HLDA !== 1'b0 || hold_active !== 1'b0) begin failures++; $display("FAIL hg_release HLDA/hold_active got=%b%b exp=00", HLDA, hold_active); end
    checks++; if (IOR_N !== 1'b0 || IOW_N !== 1'b0 || ADDRESS !== 4'h0) begin failures++; $display("FAIL hg_turnaround got=%b%b/%h exp=00/0", IOR_N, IOW_N, ADDRESS); end
    tb_bus_en = 1'b0;
    tick;
    tb_ctl_en = 1'b0; #1;
    checks++; if (IOR_N !== 1'b1 || IOW_N !== 1'b1 || cmd_ready !== 1'b1) begin failures++; $display("FAIL hg_idle IOR_N/IOW_N/cmd_ready got=%b%b%b exp=111", IOR_N, IOW_N, cmd_ready); end
  endtask

  task automatic test_collision_cmd;
    HRQ = 1'b1; cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 4'h2; cmd_wdata = 8'h11; #1;
    checks++; if (cmd_ready !== 1'b0) begin failures++; $display("FAIL col_ready got=%b exp=0", cmd_ready); end
    tick;
    checks++; if (CS_N !== 1'b1 || cmd_ready !== 1'b0) begin failures++; $display("FAIL col_wait CS_N/cmd_ready got=%b%b exp=10", CS_N, cmd_ready); end
    tick; tick;
    checks++; if (HLDA !== 1'b1) begin failures++; $display("FAIL col_hold HLDA got=%b exp=1", HLDA); end
    tb_ctl_en = 1'b1; HRQ = 1'b0;
    tick;
    checks++; if (cmd_ready !== 1'b0 || CS_N !== 1'b1) begin failures++; $display("FAIL col_release cmd_ready/CS_N got=%b%b exp=01", cmd_ready, CS_N); end
    tick;
    tb_ctl_en = 1'b0; #1;
    checks++; if (cmd_ready !== 1'b1) begin failures++; $display("FAIL col_idle_ready got=%b exp=1", cmd_ready); end
    tick;
    cmd_valid = 1'b0;
    checks++; if (CS_N !== 1'b0 || ADDRESS !== 4'h2 || DATABUS !== 8'h11) begin failures++; $display("FAIL col_cmd_setup got=%b/%h/%h exp=0/2/11", CS_N, ADDRESS, DATABUS); end
    tick; tick; tick; tick;
    checks++; if (cmd_ready !== 1'b1) begin failures++; $display("FAIL col_cmd_done got=%b exp=1", cmd_ready); end
  endtask

  task automatic test_hrq_during_strobe;
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 4'h5; cmd_wdata = 8'h3C;
    tick;
    cmd_valid = 1'b0;
    tick;
    HRQ = 1'b1;
    tick;
    checks++; if (IOW_N !== 1'b0 || CS_N !== 1'b0 || ADDRESS !== 4'h5 || HLDA !== 1'b0) begin failures++; $display("FAIL hs_strobe2 IOW_N/CS_N/ADDR/HLDA got=%b%b/%h/%b exp=00/5/0", IOW_N, CS_N, ADDRESS, HLDA); end
    tick;
    checks++; if (CS_N !== 1'b1 || HLDA !== 1'b0) begin failures++; $display("FAIL hs_recover CS_N/HLDA got=%b%b exp=10", CS_N, HLDA); end
    tick;
    checks++; if (cmd_ready !== 1'b0 || HLDA !== 1'b0) begin failures++; $display("FAIL hs_idle cmd_ready/HLDA got=%b%b exp=00", cmd_ready, HLDA); end
    tick; tick;
    checks++; if (HLDA !== 1'b0) begin failures++; $display("FAIL hs_wait HLDA got=%b exp=0", HLDA); end
    tick;
    checks++; if (HLDA !== 1'b1) begin failures++; $display("FAIL hs_hold HLDA got=%b exp=1", HLDA); end
    tb_ctl_en = 1'b1; HRQ = 1'b0;
    tick; tick;
    tb_ctl_en = 1'b0;
  endtask

  task automatic test_hrq_pulse;
    HRQ = 1'b1;
    tick;
    HRQ = 1'b0;
    tick;
    checks++; if (HLDA !== 1'b0 || cmd_ready !== 1'b1) begin failures++; $display("FAIL pulse_idle HLDA/cmd_ready got=%b%b exp=01", HLDA, cmd_ready); end
    tick; tick;
    checks++; if (HLDA !== 1'b0 || IOR_N !== 1'b1) begin failures++; $display("FAIL pulse_no_hlda HLDA/IOR_N got=%b%b exp=01", HLDA, IOR_N); end
  endtask

  task automatic test_reset_in_flight;
    HRQ = 1'b1;
    tick; tick; tick;
    checks++; if (HLDA !== 1'b1) begin failures++; $display("FAIL rh_hold HLDA got=%b exp=1", HLDA); end
    tb_ctl_en = 1'b1; RESET_N = 1'b0;
    tick;
    checks++; if (HLDA !== 1'b0 || hold_active !== 1'b0) begin failures++; $display("FAIL rh_reset HLDA/hold_active got=%b%b exp=00", HLDA, hold_active); end
    tb_ctl_en = 1'b0; HRQ = 1'b0; RESET_N = 1'b1; #1;
    checks++; if (IOR_N !== 1'b1 || IOW_N !== 1'b1) begin failures++; $display("FAIL rh_strobes got=%b%b exp=11", IOR_N, IOW_N); end
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 4'h1;
    tick;
    cmd_valid = 1'b0;
    tick;
    RESET_N = 1'b0;
    tick;
    RESET_N = 1'b1;
    checks++; if (CS_N !== 1'b1 || IOR_N !== 1'b1) begin failures++; $display("FAIL rr_abort CS_N/IOR_N got=%b%b exp=11", CS_N, IOR_N); end
    for (int i = 0; i < 4; i++) begin
      tick;
      checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL rr_no_rsp%0d got=%b exp=0", i, rsp_valid); end
    end
  endtask

`ifdef DMA_HOST_HOLD_TIMEOUT_EN
  task automatic test_hold_timeout;
    HRQ = 1'b1;
    tick; tick; tick;
    tb_ctl_en = 1'b1;
    checks++; if (hold_timeout !== 1'b0) begin failures++; $display("FAIL to_first got=%b exp=0", hold_timeout); end
    for (int i = 0; i < 14; i++) tick;
    checks++; if (hold_timeout !== 1'b0) begin failures++; $display("FAIL to_cycle15 got=%b exp=0", hold_timeout); end
    tick;
    checks++; if (hold_timeout !== 1'b1) begin failures++; $display("FAIL to_cycle16 got=%b exp=1", hold_timeout); end
    for (int i = 0; i < 4; i++) tick;
    HRQ = 1'b0;
    tick;
    checks++; if (hold_timeout !== 1'b1 || HLDA !== 1'b0) begin failures++; $display("FAIL to_release timeout/HLDA got=%b%b exp=10", hold_timeout, HLDA); end
    tick;
    tb_ctl_en = 1'b0;
    tick;
    checks++; if (hold_timeout !== 1'b1) begin failures++; $display("FAIL to_sticky got=%b exp=1", hold_timeout); end
    RESET_N = 1'b0;
    tick;
    RESET_N = 1'b1;
    checks++; if (hold_timeout !== 1'b0) begin failures++; $display("FAIL to_reset got=%b exp=0", hold_timeout); end
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached checks=%0d", checks);
    $fatal(1);
  end

  initial begin
    test_reset;
    test_write;
    test_read;
    test_hold_grant;
    test_collision_cmd;
    test_hrq_during_strobe;
    test_hrq_pulse;
    test_reset_in_flight;
`ifdef DMA_HOST_HOLD_TIMEOUT_EN
    test_hold_timeout;
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
